// File: rtl/id_operand_fwd.sv
// ID-stage operand delivery: instruction hold register plus priority forwarding with load-use stall detection.
// Optional performance counters are built when ID_OPND_FWD_PERF_EN is defined.
module id_operand_fwd #(
    parameter int DW   = 32,
    parameter int NSRC = 2,
    parameter int NFWD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_stall,
    input  logic                 id_flush,
    input  logic [31:0]          inst_sram_rdata,
    output logic [31:0]          inst_o,
    input  logic [NSRC*5-1:0]    raddr,
    input  logic [NSRC*DW-1:0]   rf_rdata,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*5-1:0]    fwd_waddr,
    input  logic [NFWD*DW-1:0]   fwd_wdata,
    input  logic [NFWD-1:0]      fwd_pend,
    output logic [NSRC*DW-1:0]   opnd_o,
    output logic                 stallreq,
    output logic [31:0]          perf_lu_stall,
    output logic [31:0]          perf_fwd_hit
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]  state_reg, state_next;
    logic [31:0] hold_reg, hold_next;

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        if (id_flush) begin
            state_next = S_IDLE;
            hold_next  = '0;
        end else if (state_reg == S_IDLE) begin
            if (id_stall) begin
                state_next = S_HOLD;
                hold_next  = inst_sram_rdata;
            end
        end else if (!id_stall) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    // The release cycle is still in HOLD, so the decoder keeps seeing the held word.
    assign inst_o = (rst || id_flush) ? 32'd0 :
                    (state_reg == S_HOLD) ? hold_reg : inst_sram_rdata;

    logic [NSRC-1:0] port_match;
    logic [NSRC-1:0] port_pend;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_port
            logic [4:0]    ra;
            logic [DW-1:0] opnd_sel;
            logic          match_sel;
            logic          pend_sel;

            assign ra = raddr[gi*5 +: 5];

            // Scan oldest to youngest so the youngest matching producer wins.
            always_comb begin
                opnd_sel  = rf_rdata[gi*DW +: DW];
                match_sel = 1'b0;
                pend_sel  = 1'b0;
                for (int j = NFWD - 1; j >= 0; j--) begin
                    if (fwd_we[j] && (fwd_waddr[j*5 +: 5] == ra)) begin
                        opnd_sel  = fwd_wdata[j*DW +: DW];
                        match_sel = 1'b1;
                        pend_sel  = fwd_pend[j];
                    end
                end
                if (ra == 5'd0) begin
                    opnd_sel  = '0;
                    match_sel = 1'b0;
                    pend_sel  = 1'b0;
                end
            end

            assign opnd_o[gi*DW +: DW] = opnd_sel;
            assign port_match[gi]      = match_sel;
            assign port_pend[gi]       = pend_sel;
        end
    endgenerate

    assign stallreq = (|(port_match & port_pend)) && !id_flush && !rst;

`ifdef ID_OPND_FWD_PERF_EN
    logic        any_hit;
    logic [31:0] lu_cnt_reg;
    logic [31:0] hit_cnt_reg;

    assign any_hit = |(port_match & ~port_pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_reg  <= '0;
            hit_cnt_reg <= '0;
        end else begin
            if (stallreq && (lu_cnt_reg != 32'hFFFF_FFFF))
                lu_cnt_reg <= lu_cnt_reg + 32'd1;
            if (any_hit && (hit_cnt_reg != 32'hFFFF_FFFF))
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
        end
    end

    assign perf_lu_stall = lu_cnt_reg;
    assign perf_fwd_hit  = hit_cnt_reg;
`else
    assign perf_lu_stall = 32'd0;
    assign perf_fwd_hit  = 32'd0;
`endif

endmodule
